// File: rtl/packetizer_arbiter_std.sv
// Round-robin arbiter that shares one packetizer input port between NUM_REQ requesters,
// with optional per-requester burst lock capped at MAX_BURST words and a registered output.
module packetizer_arbiter_std #(
  parameter int NUM_REQ          = 4,
  parameter int WIDTH_IN         = 12,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int MAX_BURST        = 4,
  parameter int REQ_IDX_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ*WIDTH_IN-1:0]           req_data_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]      req_dst_in,
  input  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0]   req_vc_in,
  input  logic [NUM_REQ-1:0]                    req_lock_in,
  input  logic [NUM_REQ-1:0]                    req_valid_in,
  output logic [NUM_REQ-1:0]                    req_ready_out,
  output logic [WIDTH_IN-1:0]                   data_out,
  output logic [ADDRESS_WIDTH-1:0]              dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0]           vc_out,
  output logic                                  valid_out,
  input  logic                                  ready_in,
  output logic [REQ_IDX_WIDTH-1:0]              src_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t                   state_q, state_d;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_WIDTH-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]         burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0]       grant;
  logic [REQ_IDX_WIDTH-1:0] grant_idx;
  logic [REQ_IDX_WIDTH-1:0] scan;
  logic                     grant_any;
  logic                     load_en;
  logic                     xfer;

  logic                        vld_p1;
  logic [WIDTH_IN-1:0]         data_p1;
  logic [ADDRESS_WIDTH-1:0]    dst_p1;
  logic [VC_ADDRESS_WIDTH-1:0] vc_p1;
  logic [REQ_IDX_WIDTH-1:0]    src_p1;

  // Explicit compare so non-power-of-2 NUM_REQ wraps correctly.
  function automatic logic [REQ_IDX_WIDTH-1:0] wrap_inc(input logic [REQ_IDX_WIDTH-1:0] idx);
    if (idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) return '0;
    return idx + REQ_IDX_WIDTH'(1);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan      = rr_ptr_q;
    if (state_q == LOCKED) begin
      grant_idx = owner_q;
      grant_any = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any && req_valid_in[scan]) begin
          grant_any = 1'b1;
          grant_idx = scan;
        end
        scan = wrap_inc(scan);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign load_en       = !vld_p1 || ready_in;
  assign req_ready_out = (rst_n && load_en) ? grant : '0;
  assign xfer          = rst_n && load_en && grant_any && req_valid_in[grant_idx];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      case (state_q)
        ARB: begin
          if (req_lock_in[grant_idx] && MAX_BURST > 1) begin
            state_d     = LOCKED;
            owner_d     = grant_idx;
            burst_cnt_d = CNT_W'(1);
          end else begin
            rr_ptr_d = wrap_inc(grant_idx);
          end
        end
        LOCKED: begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (!req_lock_in[grant_idx] || (burst_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
            state_d     = ARB;
            rr_ptr_d    = wrap_inc(grant_idx);
            burst_cnt_d = '0;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Stage p1: output register, reloaded on the same edge it drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      dst_p1  <= '0;
      vc_p1   <= '0;
      src_p1  <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= req_data_in[grant_idx*WIDTH_IN +: WIDTH_IN];
      dst_p1  <= req_dst_in[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      vc_p1   <= req_vc_in[grant_idx*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
      src_p1  <= grant_idx;
    end else if (ready_in) begin
      vld_p1  <= 1'b0;
    end
  end

  assign valid_out = vld_p1;
  assign data_out  = data_p1;
  assign dst_out   = dst_p1;
  assign vc_out    = vc_p1;
  assign src_out   = src_p1;

endmodule

// File: tb/tb_packetizer_arbiter_std.sv
// Randomized and directed bench for packetizer_arbiter_std against a transaction-level model.
module tb_packetizer_arbiter_std;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int AW = 4;
  localparam int VW = 1;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic [N*W-1:0]    req_data_in;
  logic [N*AW-1:0]   req_dst_in;
  logic [N*VW-1:0]   req_vc_in;
  logic [N-1:0]      req_lock_in;
  logic [N-1:0]      req_valid_in;
  logic [N-1:0]      req_ready_out;
  logic [W-1:0]      data_out;
  logic [AW-1:0]     dst_out;
  logic [VW-1:0]     vc_out;
  logic              valid_out;
  logic              ready_in;
  logic [IW-1:0]     src_out;

  packetizer_arbiter_std #(
    .NUM_REQ(N), .WIDTH_IN(W), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data_in(req_data_in), .req_dst_in(req_dst_in), .req_vc_in(req_vc_in),
    .req_lock_in(req_lock_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .data_out(data_out), .dst_out(dst_out), .vc_out(vc_out), .valid_out(valid_out),
    .ready_in(ready_in), .src_out(src_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: the word sitting in the output register plus the arbitration intent
  // (who owns a lock, where the next round-robin search begins, words sent in the burst).
  logic          m_vld;
  logic [W-1:0]  m_data;
  logic [AW-1:0] m_dst;
  logic [VW-1:0] m_vc;
  int            m_src;
  int            m_owner;
  int            m_start;
  int            m_words;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_start + k) % N;
      if (req_valid_in[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_data = '0; m_dst = '0; m_vc = '0; m_src = 0;
    m_owner = -1; m_start = 0; m_words = 0;
  endtask

  task automatic model_clock();
    int g;
    bit load, x;
    if (!rst_n) begin
      model_reset();
      return;
    end
    load = !m_vld || ready_in;
    g = m_grant();
    x = load && (g >= 0) && req_valid_in[g];
    if (x) begin
      m_vld  = 1'b1;
      m_data = req_data_in[g*W +: W];
      m_dst  = req_dst_in[g*AW +: AW];
      m_vc   = req_vc_in[g*VW +: VW];
      m_src  = g;
      if (m_owner < 0) begin
        if (req_lock_in[g] && MB > 1) begin
          m_owner = g; m_words = 1;
        end else begin
          m_start = (g + 1) % N;
        end
      end else begin
        m_words++;
        if (!req_lock_in[g] || m_words == MB) begin
          m_owner = -1; m_start = (g + 1) % N; m_words = 0;
        end
      end
    end else if (ready_in) begin
      m_vld = 1'b0;
    end
  endtask

  // One clock: compare everything mid-low-phase, then advance the model on the edge.
  task automatic step();
    logic [N-1:0] er;
    int g;
    #1;
    er = '0;
    g = m_grant();
    if (rst_n && (!m_vld || ready_in) && g >= 0) er[g] = 1'b1;
    chk("req_ready_out", 64'(req_ready_out), 64'(er));
    chk("valid_out", 64'(valid_out), 64'(m_vld));
    chk("data_out", 64'(data_out), 64'(m_data));
    chk("dst_out", 64'(dst_out), 64'(m_dst));
    chk("vc_out", 64'(vc_out), 64'(m_vc));
    chk("src_out", 64'(src_out), 64'(m_src));
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_all(input logic [N-1:0] valid, input logic [N-1:0] lock);
    for (int i = 0; i < N; i++) begin
      req_data_in[i*W +: W]  = W'(12'h100 + i);
      req_dst_in[i*AW +: AW] = AW'(i + 5);
      req_vc_in[i*VW +: VW]  = VW'(i % 2);
    end
    req_valid_in = valid;
    req_lock_in  = lock;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int c = 0; c < cycles; c++) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ready_in = 1'b1;
    req_data_in = '0; req_dst_in = '0; req_vc_in = '0; req_lock_in = '0; req_valid_in = '0;
    model_reset();
    @(negedge clk);

    // Reset with everyone requesting.
    set_all(4'b1111, 4'b0000);
    do_reset(2);
    chk("rst valid_out", 64'(valid_out), 64'd0);
    chk("rst src_out", 64'(src_out), 64'd0);
    chk("rst data_out", 64'(data_out), 64'd0);
    #1 chk("first grant", 64'(req_ready_out), 64'b0001);

    // Plain round robin.
    begin
      logic [W-1:0] exp_seq [5];
      exp_seq = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h100};
      for (int k = 0; k < 5; k++) begin
        step();
        chk("rr data", 64'(data_out), 64'(exp_seq[k]));
        chk("rr dst", 64'(dst_out), 64'((k % 4) + 5));
        chk("rr vc", 64'(vc_out), 64'(k % 2));
      end
    end

    // Lock from req 2 starting at pointer 2.
    do_reset(1);
    set_all(4'b0001, 4'b0000); step();
    set_all(4'b0010, 4'b0000); step();
    begin
      int exp_src [6];
      logic [N-1:0] lk [6];
      exp_src = '{2, 2, 2, 3, 0, 1};
      lk = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      for (int k = 0; k < 6; k++) begin
        set_all(4'b1111, lk[k]);
        if (k > 0 && k < 3) #1 chk("lock others ready", 64'(req_ready_out), 64'b0100);
        step();
        chk("lock src", 64'(src_out), 64'(exp_src[k]));
      end
    end

    // Burst cap.
    do_reset(1);
    begin
      int exp_src [6];
      exp_src = '{1, 1, 1, 1, 2, 1};
      for (int k = 0; k < 6; k++) begin
        set_all(4'b0110, 4'b0010);
        step();
        chk("burst src", 64'(src_out), 64'(exp_src[k]));
      end
    end

    // Backpressure.
    do_reset(1);
    set_all(4'b1111, 4'b0000);
    step();
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp ready", 64'(req_ready_out), 64'd0);
      step();
      chk("bp hold data", 64'(data_out), 64'h100);
      chk("bp hold valid", 64'(valid_out), 64'd1);
    end
    ready_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("bp release data", 64'(data_out), 64'(12'h100 + k));
    end

    // Reset in the middle of a lock.
    do_reset(1);
    set_all(4'b1000, 4'b1000); step();
    chk("mid-lock src", 64'(src_out), 64'd3);
    set_all(4'b1111, 4'b1000);
    rst_n = 1'b0; step();
    chk("mid-lock rst valid", 64'(valid_out), 64'd0);
    rst_n = 1'b1;
    set_all(4'b1111, 4'b0000); step();
    chk("post-rst src", 64'(src_out), 64'd0);
    step();
    chk("no resume src", 64'(src_out), 64'd1);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      ready_in = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        req_data_in[i*W +: W]  = W'($urandom);
        req_dst_in[i*AW +: AW] = AW'($urandom);
        req_vc_in[i*VW +: VW]  = VW'($urandom);
        req_valid_in[i]        = ($urandom_range(0, 3) != 0);
        req_lock_in[i]         = ($urandom_range(0, 2) != 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packetizer_arbiter_std.md
Name: packetizer_arbiter_std

Overview:
- Shares one packetizer input port (data/dst/vc with valid/ready) between NUM_REQ local requesters.
- Sits between several module-side sources and a single packetizer_std instance.
- Round-robin arbitration per word, with an optional per-requester lock so a multi-word message stays contiguous; the lock is capped at MAX_BURST words.
- One registered output stage, so the outputs connect directly to packetizer_std data_in/dst_in/vc_in/valid_in/ready_out.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- WIDTH_IN, 12, data word width per requester.
- ADDRESS_WIDTH, 4, router address width of dst.
- VC_ADDRESS_WIDTH, 1, VC id width.
- MAX_BURST, 4, maximum consecutive words one requester may send under lock (≥1).
- REQ_IDX_WIDTH, $clog2(NUM_REQ), derived; source index width.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, reset: synchronous, active-low.
- req_data_in, input, NUM_REQ*WIDTH_IN, requester i data at slice i.
- req_dst_in, input, NUM_REQ*ADDRESS_WIDTH, requester i destination router.
- req_vc_in, input, NUM_REQ*VC_ADDRESS_WIDTH, requester i VC.
- req_lock_in, input, NUM_REQ, 1 = keep grant after this word.
- req_valid_in, input, NUM_REQ, requester i word valid.
- req_ready_out, output, NUM_REQ, requester i word accepted this cycle when valid&ready.
- data_out, output, WIDTH_IN, to packetizer data_in.
- dst_out, output, ADDRESS_WIDTH, to packetizer dst_in.
- vc_out, output, VC_ADDRESS_WIDTH, to packetizer vc_in.
- valid_out, output, 1, to packetizer valid_in.
- ready_in, input, 1, from packetizer ready_out.
- src_out, output, REQ_IDX_WIDTH, requester index that produced the current data_out.

Behaviour:
- Output register:
  - load_en = !valid_out | ready_in.
  - A transfer from requester g occurs when load_en & grant[g] & req_valid_in[g].
  - On a transfer the register captures data/dst/vc/src and sets valid_out=1.
  - When ready_in=1 and no transfer occurs, valid_out clears.
  - Simultaneous drain and load: the register is replaced in the same cycle, with no bubble.
- Latency: 1 cycle from requester handshake to valid_out.
- Throughput: 1 word/cycle sustained.
- Held outputs: while valid_out=1 & ready_in=0, data_out, dst_out, vc_out and src_out are held stable.
- req_ready_out[i] = load_en & grant[i]. It is combinational from ready_in and is never asserted for more than one requester.
- FSM states: ARB and LOCKED.
  - ARB: grant = first requester with req_valid_in=1, scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 … NUM_REQ-1, 0 …). No valid requester → grant is zero.
  - ARB on a transfer from g:
    - if req_lock_in[g]=1 and MAX_BURST>1: go to LOCKED, owner=g, burst_cnt=1.
    - otherwise: stay in ARB, rr_ptr=(g+1) mod NUM_REQ.
  - ARB with no transfer (empty, or backpressure): rr_ptr is unchanged.
  - LOCKED: grant is only the owner. Other requesters get ready=0 even if the owner's valid is low (idle bubbles are allowed; the lock persists).
  - LOCKED on an owner transfer:
    - burst_cnt increments.
    - If req_lock_in[owner]=0, or burst_cnt+1==MAX_BURST: return to ARB, rr_ptr=(owner+1) mod NUM_REQ, burst_cnt=0.
  - Any state, ready_in held low: no state/pointer change.
- Width rules:
  - burst_cnt width is $clog2(MAX_BURST+1).
  - rr_ptr wrap uses an explicit compare to NUM_REQ-1, so non-power-of-2 NUM_REQ is supported.
- Reset (rst_n=0 at a clock edge):
  - valid_out=0; data_out, dst_out, vc_out, src_out = 0.
  - state=ARB, rr_ptr=0, burst_cnt=0, req_ready_out=0 during reset.
- Reset mid-operation: the lock is dropped, any word in the output register is discarded, and arbitration restarts at requester 0.
- No combinational path from req_valid_in to valid_out.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with all req_valid_in=1 → valid_out=0, src_out=0, req_ready_out=0000; first cycle after release grants req 0.
2. All 4 requesters valid, lock=0, ready_in=1, data_i=0x100+i → data_out sequence 0x100,0x101,0x102,0x103,0x100 on consecutive cycles, with dst/vc matching each source.
3. Req 2 sends 3 words lock=1,1,0 while req 0/1/3 stay valid, starting from rr_ptr=2 → src_out 2,2,2 then 3,0,1; req 0/1/3 ready=0 during the lock.
4. MAX_BURST=4, req 1 holds lock=1 continuously and req 2 is valid → exactly 4 words from req 1, then src_out=2, then req 1 re-granted on the next turn.
5. Backpressure: ready_in=0 for 3 cycles with valid_out=1 → outputs stable and all req_ready_out=0; after release every word appears exactly once, in order, with no loss or duplication.
6. Reset mid-lock: rst_n=0 during req 3's second locked word → valid_out=0 the next cycle; after release req 0 (if valid) wins and the lock is not resumed.
